// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Purpose : load-use stall, redirect flush and syscall drain/halt sequencer
//           for the 5-stage MIPS pipeline. Optional HAZARD_PERF_EN adds
//           flush_cnt and cycle_cnt performance counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_syscall,
    input  logic             ex_memtoreg,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
`endif
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALT   = 2'd2;
    localparam logic [1:0] S_RESUME = 2'd3;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [DW-1:0] drain_cnt;
    logic          lu;
    logic          lu_stall;

    assign lu = ex_memtoreg && (ex_rd != 5'd0) &&
                ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

    // Redirect and syscall both outrank the load-use stall in RUN.
    assign lu_stall = (state == S_RUN) && !ex_redirect && !id_syscall && lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_RUN: begin
                if (!ex_redirect && id_syscall) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = S_HALT;
                end
            end
            S_HALT: begin
                if (resume) begin
                    next_state = S_RESUME;
                end
            end
            default: next_state = S_RUN;
        endcase
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        case (state)
            S_RUN: begin
                if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (id_syscall || lu) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            S_DRAIN, S_HALT: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            default: begin
                ifid_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            if (state == S_RUN && next_state == S_DRAIN) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == S_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            halted <= (next_state == S_HALT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (lu_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            if ((state == S_RUN) && ex_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if ((state != S_HALT) && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module  : tb_hazard_ctrl
// Purpose : directed self-checking bench for hazard_ctrl (queue scoreboard).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_use_rs, id_use_rt, id_syscall, ex_memtoreg, ex_redirect, resume;
    logic          pc_en, ifid_en, ifid_flush, idex_flush, halted;
    logic [CW-1:0] stall_cnt;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] flush_cnt, cycle_cnt;
`endif

    hazard_ctrl #(.DRAIN_CYC(3), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .id_syscall  (id_syscall),
        .ex_memtoreg (ex_memtoreg),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .resume      (resume),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .halted      (halted),
`ifdef HAZARD_PERF_EN
        .flush_cnt   (flush_cnt),
        .cycle_cnt   (cycle_cnt),
`endif
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string         tag;
        logic          halted;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
        logic [CW-1:0] cyc;
    } post_t;

    post_t         sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_stall = '0;
    logic [CW-1:0] exp_flush = '0;
    logic [CW-1:0] exp_cyc   = '0;
    logic          exp_halt  = 1'b0;

    localparam logic [3:0] O_RUN  = 4'b1100;
    localparam logic [3:0] O_STL  = 4'b0001;
    localparam logic [3:0] O_FLS  = 4'b1111;
    localparam logic [3:0] O_RES  = 4'b1110;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_syscall = 1'b0; ex_memtoreg = 1'b0; ex_rd = 5'd0;
        ex_redirect = 1'b0; resume = 1'b0;
    endtask

    // Drive one cycle, check combinational outputs before the edge, and
    // queue the expected registered state to be checked after the edge.
    task automatic step(input string tag,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic sys,
                        input logic mtr, input logic [4:0] rd,
                        input logic redir, input logic res,
                        input logic [3:0] e_out, input logic e_halt_next,
                        input logic counts_stall);
        post_t p;
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_syscall = sys; ex_memtoreg = mtr; ex_rd = rd;
        ex_redirect = redir; resume = res;
        #2;
        chk({tag, ".out"}, {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, {28'd0, e_out});
        if (counts_stall && exp_stall != '1) exp_stall = exp_stall + 1'b1;
        if (e_out == O_FLS && exp_flush != '1) exp_flush = exp_flush + 1'b1;
        if (!exp_halt && exp_cyc != '1) exp_cyc = exp_cyc + 1'b1;
        exp_halt = e_halt_next;
        sb.push_back('{tag, e_halt_next, exp_stall, exp_flush, exp_cyc});
        @(posedge clk);
        #1;
        p = sb.pop_front();
        chk({p.tag, ".halted"}, {31'd0, halted}, {31'd0, p.halted});
        chk({p.tag, ".stall_cnt"}, {24'd0, stall_cnt}, {24'd0, p.stall});
`ifdef HAZARD_PERF_EN
        chk({p.tag, ".flush_cnt"}, {24'd0, flush_cnt}, {24'd0, p.flush});
        chk({p.tag, ".cycle_cnt"}, {24'd0, cycle_cnt}, {24'd0, p.cyc});
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".out"}, {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, {28'd0, O_RUN});
        chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
        chk({tag, ".stall_cnt"}, {24'd0, stall_cnt}, 32'd0);
`ifdef HAZARD_PERF_EN
        chk({tag, ".flush_cnt"}, {24'd0, flush_cnt}, 32'd0);
        chk({tag, ".cycle_cnt"}, {24'd0, cycle_cnt}, 32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #12;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // load-use on rs, then on rt, one bubble each
        step("lu_rs",     5'd8, 5'd3, 1, 0, 0, 1, 5'd8, 0, 0, O_STL, 0, 1);
        step("lu_rs_nxt", 5'd8, 5'd3, 1, 0, 0, 0, 5'd0, 0, 0, O_RUN, 0, 0);
        step("lu_rt",     5'd1, 5'd9, 1, 1, 0, 1, 5'd9, 0, 0, O_STL, 0, 1);
        step("lu_rt_nxt", 5'd1, 5'd9, 1, 1, 0, 0, 5'd0, 0, 0, O_RUN, 0, 0);

        // no-stall corner cases
        step("rd_zero",   5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0, 0, O_RUN, 0, 0);
        step("rt_unused", 5'd2, 5'd8, 1, 0, 0, 1, 5'd8, 0, 0, O_RUN, 0, 0);
        step("not_load",  5'd8, 5'd8, 1, 1, 0, 0, 5'd8, 0, 0, O_RUN, 0, 0);

        // redirect outranks load-use and syscall
        step("redir1",    5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 1, 0, O_FLS, 0, 0);
        step("redir1_nx", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, O_RUN, 0, 0);
        step("redir2",    5'd0, 5'd7, 0, 1, 1, 1, 5'd7, 1, 0, O_FLS, 0, 0);
        step("redir2_nx", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, O_RUN, 0, 0);

        // syscall: drain 3 cycles, halt, resume
        step("sys",       5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, O_STL, 0, 0);
        step("drain2",    5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 1, O_STL, 0, 0);
        step("drain1",    5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 1, 0, O_STL, 0, 0);
        step("drain0",    5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 1, O_STL, 1, 0);
        step("halt_lu",   5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 0, O_STL, 1, 0);
        step("halt_hold", 5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, O_STL, 1, 0);
        step("halt_res",  5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 1, O_STL, 0, 0);
        step("resume",    5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 0, O_RES, 0, 0);
        step("run_again", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, O_RUN, 0, 0);

        // asynchronous reset while halted
        step("sys_b",     5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, O_STL, 0, 0);
        step("drain2_b",  5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, O_STL, 0, 0);
        step("drain1_b",  5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, O_STL, 0, 0);
        step("drain0_b",  5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 0, O_STL, 1, 0);
        idle();
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        rst_n = 1'b1;
        exp_stall = '0;
        exp_flush = '0;
        exp_cyc   = '0;
        exp_halt  = 1'b0;
        step("post_rst",  5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, O_RUN, 0, 0);

        // saturate stall_cnt
        for (int i = 0; i < (1 << CW) + 4; i++) begin
            step("sat", 5'd4, 5'd0, 1, 0, 0, 1, 5'd4, 0, 0, O_STL, 0, 1);
        end
        chk("sat_final", {24'd0, stall_cnt}, {24'd0, {CW{1'b1}}});
        step("sat_idle",  5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, O_RUN, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
